delayed_and_gate: RTL and testbench



---
 rtl/delayed_and_gate.sv | 179 +++++++++++++++++
 tb/tb_delayed_and_gate.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delayed_and_gate.sv
// delayed_and_gate
//   CHANNELS independent AND gates with INPUTS inputs each, whose results reach
//   the outputs DELAY clock cycles late. Each channel has two delay models,
//   selected at run time:
//     mode = 1 : transport. A DELAY-stage shift register reproduces every pulse,
//                however narrow, with its width preserved.
//     mode = 0 : inertial. A per-channel IDLE/PEND FSM with a cycle counter
//                swallows any pulse narrower than DELAY cycles.
//   Changing mode flushes the edges still in flight and holds the outputs, so
//   the new model starts from a clean state.
//   Optional feature macro: DELAYED_AND_GLITCH_COUNT_EN
//     When defined, a glitch_cnt port is added. It holds one 8-bit saturating
//     counter per channel that counts inertial swallows.
module delayed_and_gate #(
  parameter int CHANNELS = 4,
  parameter int INPUTS   = 2,
  parameter int DELAY    = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic [CHANNELS*INPUTS-1:0]    in,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS-1:0]           busy
`ifdef DELAYED_AND_GLITCH_COUNT_EN
  ,
  output logic [CHANNELS*8-1:0]         glitch_cnt
`endif
);

  // Inertial counter width. It is derived from DELAY and is not meant to be overridden.
  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Registered copy of mode. A difference from the pin marks the flush edge.
  logic r_mode;
  logic w_mode_chg;

  assign w_mode_chg = (mode != r_mode);

  // Track the mode pin. During reset it is captured directly, so that the
  // first edge after release is never mistaken for a mode change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= mode;
    end else begin
      r_mode <= mode;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic          w_a;
      logic          r_out;
      state_t        r_state;
      state_t        w_state_next;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_next;
      logic          w_out_next;
      logic          w_tx_next;
      logic          w_tx_busy;

      assign w_a = &in[gi*INPUTS +: INPUTS];

      // Transport path. The output register is the last stage of the delay
      // line, so only DELAY-1 extra stages are stored here.
      if (DELAY > 1) begin : g_pipe
        logic [DELAY-2:0] r_pipe;

        // Shift in a in transport mode. On a mode change, load every stage with out.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_pipe <= '0;
          end else if (w_mode_chg) begin
            r_pipe <= {(DELAY-1){r_out}};
          end else if (r_mode) begin
            r_pipe[0] <= w_a;
            for (int s = 1; s < DELAY - 1; s++) begin
              r_pipe[s] <= r_pipe[s-1];
            end
          end
        end

        assign w_tx_next = r_pipe[DELAY-2];
        assign w_tx_busy = |(r_pipe ^ {(DELAY-1){r_out}});
      end else begin : g_nopipe
        assign w_tx_next = w_a;
        assign w_tx_busy = 1'b0;
      end

      // Inertial next-state logic: confirm a changed input only after it has
      // been held for DELAY samples.
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_out_next   = r_out;
        case (r_state)
          IDLE: begin
            w_cnt_next = '0;
            if (w_a != r_out) begin
              if (DELAY == 1) begin
                w_out_next = w_a;
              end else begin
                w_state_next = PEND;
                w_cnt_next   = CNT_ONE;
              end
            end
          end
          PEND: begin
            if (w_a == r_out) begin
              w_state_next = IDLE;
              w_cnt_next   = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_out_next   = w_a;
              w_state_next = IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
          default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end
        endcase
      end

      // Channel state: reset, then mode-change flush, then the active model.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_out   <= 1'b0;
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (w_mode_chg) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (r_mode) begin
          r_out   <= w_tx_next;
          r_state <= IDLE;
          r_cnt   <= '0;
        end else begin
          r_out   <= w_out_next;
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      assign out[gi]  = r_out;
      assign busy[gi] = r_mode ? w_tx_busy : (r_state == PEND);

`ifdef DELAYED_AND_GLITCH_COUNT_EN
      logic [7:0] r_glitch;

      // Count inertial swallows (PEND -> IDLE with the input back at out).
      // The counter saturates at 255.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_glitch <= 8'd0;
        end else if (!w_mode_chg && !r_mode && (r_state == PEND) &&
                     (w_a == r_out) && (r_glitch != 8'hFF)) begin
          r_glitch <= r_glitch + 8'd1;
        end
      end

      assign glitch_cnt[gi*8 +: 8] = r_glitch;
`else
      // Glitch counters are not built in this configuration.
`endif
    end
  endgenerate

endmodule

// File: tb/tb_delayed_and_gate.sv
// Directed testbench for delayed_and_gate (CHANNELS=4, INPUTS=2, DELAY=10).
// Step n means the n-th rising edge that samples a new input value. The
// outputs are checked 1 ns after that edge.
`timescale 1ns/1ps
module tb_delayed_and_gate;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [7:0] in_v;
  logic [3:0] out_v;
  logic [3:0] busy_v;
`ifdef DELAYED_AND_GLITCH_COUNT_EN
  logic [31:0] glitch_v;
`endif

  int total = 0;
  int bad   = 0;

  delayed_and_gate #(
    .CHANNELS(4),
    .INPUTS  (2),
    .DELAY   (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in        (in_v),
    .out       (out_v),
    .busy      (busy_v)
`ifdef DELAYED_AND_GLITCH_COUNT_EN
    ,
    .glitch_cnt(glitch_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst_n = 1'b0;
    mode  = m;
    in_v  = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reset clears everything. With all inputs held high in inertial mode, out
  // rises on the 10th sampled edge.
  task automatic test_reset();
    logic [3:0] eo, eb;
    rst_n = 1'b0;
    mode  = 1'b0;
    in_v  = 8'hFF;
    step();
    step();
    total++;
    if (out_v !== 4'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out_v); end
    total++;
    if (busy_v !== 4'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_v); end
`ifdef DELAYED_AND_GLITCH_COUNT_EN
    total++;
    if (glitch_v !== 32'h0) begin bad++; $display("FAIL reset_glitch got=%h exp=0", glitch_v); end
`endif
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      eo = (n >= 10) ? 4'hF : 4'h0;
      eb = (n < 10) ? 4'hF : 4'h0;
      total++;
      if (out_v !== eo) begin bad++; $display("FAIL release_out n=%0d got=%h exp=%h", n, out_v, eo); end
      total++;
      if (busy_v !== eb) begin bad++; $display("FAIL release_busy n=%0d got=%h exp=%h", n, busy_v, eb); end
    end
    $display("test_reset done");
  endtask

  // Inertial mode: a 5-cycle pulse on ch0 is swallowed.
  task automatic test_inertial_swallow();
    do_reset(1'b0);
    in_v = 8'h03;
    for (int n = 1; n <= 5; n++) begin
      step();
      total++;
      if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL swallow_busy n=%0d got=%b exp=1", n, busy_v[0]); end
      total++;
      if (out_v[0] !== 1'b0) begin bad++; $display("FAIL swallow_out n=%0d got=%b exp=0", n, out_v[0]); end
    end
    in_v = 8'h01;
    step();
    total++;
    if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL swallow_busy_drop got=%b exp=0", busy_v[0]); end
    for (int n = 1; n <= 15; n++) begin
      step();
      total++;
      if (out_v[0] !== 1'b0) begin bad++; $display("FAIL swallow_after n=%0d got=%b exp=0", n, out_v[0]); end
    end
`ifdef DELAYED_AND_GLITCH_COUNT_EN
    total++;
    if (glitch_v[7:0] !== 8'd1) begin bad++; $display("FAIL swallow_glitch got=%0d exp=1", glitch_v[7:0]); end
`endif
    $display("test_inertial_swallow done");
  endtask

  // Transport mode: a 1-cycle pulse on ch1 appears for exactly one cycle at step 10.
  task automatic test_transport_pulse();
    logic eo, eb;
    do_reset(1'b1);
    for (int n = 1; n <= 12; n++) begin
      in_v = (n == 1) ? 8'h0C : 8'h00;
      step();
      eo = (n == 10);
      eb = (n <= 10);
      total++;
      if (out_v[1] !== eo) begin bad++; $display("FAIL tpulse_out n=%0d got=%b exp=%b", n, out_v[1], eo); end
      total++;
      if (busy_v[1] !== eb) begin bad++; $display("FAIL tpulse_busy n=%0d got=%b exp=%b", n, busy_v[1], eb); end
    end
`ifdef DELAYED_AND_GLITCH_COUNT_EN
    total++;
    if (glitch_v[15:8] !== 8'd0) begin bad++; $display("FAIL tpulse_glitch got=%0d exp=0", glitch_v[15:8]); end
`endif
    $display("test_transport_pulse done");
  endtask

  // Inertial boundary on ch2: a 9-cycle pulse is swallowed; a 10-cycle pulse
  // shows on out for steps 10..19.
  task automatic test_inertial_boundary();
    logic eo;
    do_reset(1'b0);
    for (int n = 1; n <= 21; n++) begin
      in_v = (n <= 9) ? 8'h30 : 8'h00;
      step();
      total++;
      if (out_v[2] !== 1'b0) begin bad++; $display("FAIL bound9_out n=%0d got=%b exp=0", n, out_v[2]); end
    end
    for (int n = 1; n <= 22; n++) begin
      in_v = (n <= 10) ? 8'h30 : 8'h00;
      step();
      eo = (n >= 10) && (n <= 19);
      total++;
      if (out_v[2] !== eo) begin bad++; $display("FAIL bound10_out n=%0d got=%b exp=%b", n, out_v[2], eo); end
    end
    $display("test_inertial_boundary done");
  endtask

  // Mode switch with edges queued on ch2: the queued edges are dropped and out holds.
  task automatic test_mode_switch();
    do_reset(1'b1);
    for (int n = 1; n <= 3; n++) begin
      in_v = (n == 2) ? 8'h00 : 8'h30;
      step();
    end
    mode = 1'b0;
    in_v = 8'h00;
    step();
    total++;
    if (busy_v !== 4'h0) begin bad++; $display("FAIL msw_busy got=%h exp=0", busy_v); end
    total++;
    if (out_v[2] !== 1'b0) begin bad++; $display("FAIL msw_out got=%b exp=0", out_v[2]); end
    for (int n = 1; n <= 12; n++) begin
      step();
      total++;
      if (out_v[2] !== 1'b0) begin bad++; $display("FAIL msw_inert_out n=%0d got=%b exp=0", n, out_v[2]); end
    end
    mode = 1'b1;
    step();
    for (int n = 1; n <= 12; n++) begin
      step();
      total++;
      if (out_v[2] !== 1'b0) begin bad++; $display("FAIL msw_back_out n=%0d got=%b exp=0", n, out_v[2]); end
    end
    // Second part: with out high, a queued falling edge is dropped and out stays high.
    in_v = 8'h30;
    for (int n = 1; n <= 12; n++) step();
    total++;
    if (out_v[2] !== 1'b1) begin bad++; $display("FAIL msw_high_pre got=%b exp=1", out_v[2]); end
    in_v = 8'h00;
    for (int n = 1; n <= 3; n++) step();
    mode = 1'b0;
    in_v = 8'h30;
    step();
    total++;
    if (busy_v[2] !== 1'b0) begin bad++; $display("FAIL msw_high_busy got=%b exp=0", busy_v[2]); end
    for (int n = 1; n <= 15; n++) begin
      step();
      total++;
      if (out_v[2] !== 1'b1) begin bad++; $display("FAIL msw_high_hold n=%0d got=%b exp=1", n, out_v[2]); end
    end
    $display("test_mode_switch done");
  endtask

  // Inertial PEND interrupted by a switch to transport: flushed, not counted as a glitch.
  task automatic test_back_to_back();
    do_reset(1'b0);
    in_v = 8'h03;
    for (int n = 1; n <= 4; n++) step();
    total++;
    if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_pend got=%b exp=1", busy_v[0]); end
    mode = 1'b1;
    in_v = 8'h00;
    step();
    total++;
    if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", busy_v[0]); end
`ifdef DELAYED_AND_GLITCH_COUNT_EN
    total++;
    if (glitch_v[7:0] !== 8'd0) begin bad++; $display("FAIL b2b_glitch got=%0d exp=0", glitch_v[7:0]); end
`endif
    for (int n = 1; n <= 12; n++) begin
      step();
      total++;
      if (out_v !== 4'h0) begin bad++; $display("FAIL b2b_out n=%0d got=%h exp=0", n, out_v); end
    end
    $display("test_back_to_back done");
  endtask

  // Reset in the middle of transport activity: nothing emerges afterwards.
  task automatic test_reset_midflight();
    do_reset(1'b1);
    in_v = 8'hFF;
    for (int n = 1; n <= 5; n++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_v  = 8'h00;
    for (int n = 1; n <= 15; n++) begin
      step();
      total++;
      if ((out_v !== 4'h0) || (busy_v !== 4'h0)) begin
        bad++;
        $display("FAIL midrst n=%0d got out=%h busy=%h exp out=0 busy=0", n, out_v, busy_v);
      end
    end
    $display("test_reset_midflight done");
  endtask

  // 300 three-cycle pulses on ch3 in inertial mode: all are swallowed and the counter saturates.
  task automatic test_saturation();
    int high_seen;
    high_seen = 0;
    do_reset(1'b0);
    for (int p = 0; p < 300; p++) begin
      for (int n = 0; n < 4; n++) begin
        in_v = (n < 3) ? 8'hC0 : 8'h00;
        step();
        if (out_v[3] !== 1'b0) high_seen++;
      end
`ifdef DELAYED_AND_GLITCH_COUNT_EN
      if (p == 9) begin
        total++;
        if (glitch_v[31:24] !== 8'd10) begin bad++; $display("FAIL sat_mid got=%0d exp=10", glitch_v[31:24]); end
      end
`endif
    end
    total++;
    if (high_seen !== 0) begin bad++; $display("FAIL sat_out_high got=%0d steps exp=0", high_seen); end
`ifdef DELAYED_AND_GLITCH_COUNT_EN
    total++;
    if (glitch_v[31:24] !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", glitch_v[31:24]); end
    total++;
    if (glitch_v[23:0] !== 24'h0) begin bad++; $display("FAIL sat_others got=%h exp=0", glitch_v[23:0]); end
`endif
    $display("test_saturation done");
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1'b0;
    in_v  = 8'h00;
    test_reset();
    test_inertial_swallow();
    test_transport_pulse();
    test_inertial_boundary();
    test_mode_switch();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
